// File: rtl/spike_dec_pkg.sv
// Shared types and default sizing for the spike rate/ISI decoder.
package spike_dec_pkg;

  localparam int unsigned DefWinW = 8;
  localparam int unsigned DefCntW = 8;
  localparam int unsigned DefIsiW = 8;

  localparam int unsigned DefCntMax = (1 << DefCntW) - 1;
  localparam int unsigned DefIsiMax = (1 << DefIsiW) - 1;

  typedef enum logic [0:0] {
    StIdle,
    StCount
  } state_e;

endpackage

// File: rtl/isi_timer.sv
// Inter-spike interval timer: saturating cycle counter between consecutive events,
// first event after a clear only arms the timer.
module isi_timer
  import spike_dec_pkg::*;
#(
  parameter int unsigned ISI_W = DefIsiW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic             i_event,
  output logic [ISI_W-1:0] o_isi,
  output logic             o_isi_valid
);

  localparam logic [ISI_W-1:0] IsiMax = '1;

  logic [ISI_W-1:0] r_ctr;
  logic             r_armed;
  logic [ISI_W-1:0] r_isi;
  logic             r_isi_valid;
  logic [ISI_W-1:0] w_ctr_inc;

  assign w_ctr_inc = (r_ctr == IsiMax) ? IsiMax : r_ctr + ISI_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctr       <= '0;
      r_armed     <= 1'b0;
      r_isi       <= '0;
      r_isi_valid <= 1'b0;
    end else begin
      r_isi_valid <= 1'b0;
      if (i_clear) begin
        r_ctr   <= '0;
        r_armed <= 1'b0;
      end else if (i_run) begin
        if (i_event) begin
          // Interval is ctr+1 because the counter restarts at 0 on the event edge.
          if (r_armed) begin
            r_isi       <= w_ctr_inc;
            r_isi_valid <= 1'b1;
          end
          r_ctr   <= '0;
          r_armed <= 1'b1;
        end else begin
          r_ctr <= w_ctr_inc;
        end
      end
    end
  end

  assign o_isi       = r_isi;
  assign o_isi_valid = r_isi_valid;

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a single-bit spike stream into a windowed spike count (rate) and the
// interval between consecutive spike events (ISI).
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int unsigned WIN_W = DefWinW,
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned ISI_W = DefIsiW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_spike_d;
  logic [WIN_W-1:0] r_win_ctr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat_w;
  logic [CNT_W-1:0] r_rate_out;
  logic             r_rate_valid;
  logic             r_rate_sat;

  logic             w_event;
  logic [WIN_W-1:0] w_win_len_m1;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_cnt_ovf;

  assign w_event      = spike_in & ~r_spike_d;
  // window_len of 0 wraps to all-ones, giving the full 2^WIN_W window.
  assign w_win_len_m1 = window_len - WIN_W'(1);
  assign w_cnt_ovf    = w_event & (r_cnt == CntMax);
  assign w_cnt_inc    = w_cnt_ovf ? r_cnt : r_cnt + CNT_W'(w_event);

  always_comb begin
    w_state_next = r_state;
    if (r_state == StIdle) begin
      if (enable) w_state_next = StCount;
    end else begin
      if (!enable) w_state_next = StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_spike_d    <= 1'b0;
      r_win_ctr    <= '0;
      r_cnt        <= '0;
      r_sat_w      <= 1'b0;
      r_rate_out   <= '0;
      r_rate_valid <= 1'b0;
      r_rate_sat   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_spike_d    <= spike_in;
      r_rate_valid <= 1'b0;
      if (enable) begin
        if (r_state == StIdle || r_win_ctr == '0) begin
          if (r_state == StCount) begin
            r_rate_out   <= w_cnt_inc;
            r_rate_sat   <= r_sat_w | w_cnt_ovf;
            r_rate_valid <= 1'b1;
          end
          r_win_ctr <= w_win_len_m1;
          r_cnt     <= '0;
          r_sat_w   <= 1'b0;
        end else begin
          r_cnt     <= w_cnt_inc;
          r_sat_w   <= r_sat_w | w_cnt_ovf;
          r_win_ctr <= r_win_ctr - WIN_W'(1);
        end
      end
    end
  end

  isi_timer #(
    .ISI_W(ISI_W)
  ) u_isi_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (r_state == StIdle),
    .i_run      ((r_state == StCount) & enable),
    .i_event    (w_event),
    .o_isi      (isi_out),
    .o_isi_valid(isi_valid)
  );

  assign rate_out   = r_rate_out;
  assign rate_valid = r_rate_valid;
  assign rate_sat   = r_rate_sat;

endmodule
